// File: rtl/test_status_monitor.sv
// rtl/test_status_monitor.sv - end-of-test monitor for riscv-tests runs
// Shadows test-number/pass registers from write-back, flags the outcome and dumps the regfile on failure.
module test_status_monitor #(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int TNUM_REG = 3,
  parameter int DONE_REG = 26,
  parameter int PASS_REG = 27,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             retire,
  output logic [4:0]       rd_addr,
  input  logic [XLEN-1:0]  rd_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-1:0]  fail_testnum,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [XLEN-1:0]  dump_data
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_DUMP_REQ = 2'd1;
  localparam logic [1:0] ST_DUMP_OUT = 2'd2;
  localparam logic [1:0] ST_FINAL    = 2'd3;

  localparam logic [4:0]       TNUM_A   = 5'(TNUM_REG);
  localparam logic [4:0]       DONE_A   = 5'(DONE_REG);
  localparam logic [4:0]       PASS_A   = 5'(PASS_REG);
  localparam logic [4:0]       LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [63:0]      TO_LAST  = 64'(TIMEOUT) - 64'd1;

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  tnum_q, tnum_d;
  logic [XLEN-1:0]  pass_sh_q, pass_sh_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [XLEN-1:0]  testnum_q, testnum_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [4:0]       idx_q, idx_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  dump_data_q, dump_data_d;
  logic             finish;
  logic             to_hit;

  always_comb begin
    state_d     = state_q;
    tnum_d      = tnum_q;
    pass_sh_d   = pass_sh_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    testnum_d   = testnum_q;
    cycle_d     = cycle_q;
    instret_d   = instret_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    dump_data_d = dump_data_q;
    finish      = 1'b0;
    to_hit      = 1'b0;

    if (clear) begin
      state_d     = ST_RUN;
      tnum_d      = '0;
      pass_sh_d   = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
      testnum_d   = '0;
      cycle_d     = '0;
      instret_d   = '0;
      idx_d       = '0;
      rd_addr_d   = '0;
      dump_data_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          finish = wb_en && (wb_addr == DONE_A) && (wb_data == ONE);
          to_hit = TO_EN && (64'(cycle_q) == TO_LAST) && !finish;
          if (wb_en && (wb_addr != 5'd0)) begin
            if (wb_addr == TNUM_A) tnum_d = wb_data;
            if (wb_addr == PASS_A) pass_sh_d = wb_data;
          end
          // The cycle count stays at TIMEOUT-1 so it reads back the count that expired.
          if (!to_hit && (cycle_q != CNT_MAX)) cycle_d = cycle_q + 1'b1;
          if (retire && (instret_q != CNT_MAX)) instret_d = instret_q + 1'b1;
          if (finish || to_hit) begin
            done_d    = 1'b1;
            testnum_d = tnum_q;
          end
          if (finish && (pass_sh_q == ONE)) begin
            pass_d  = 1'b1;
            state_d = ST_FINAL;
          end else if (finish || to_hit) begin
            fail_d    = finish;
            timeout_d = to_hit;
            idx_d     = '0;
            rd_addr_d = '0;
            state_d   = ST_DUMP_REQ;
          end
        end
        ST_DUMP_REQ: begin
          dump_data_d = rd_data;
          state_d     = ST_DUMP_OUT;
        end
        ST_DUMP_OUT: begin
          if (dump_ready) begin
            if (idx_q == LAST_IDX) begin
              rd_addr_d = '0;
              state_d   = ST_FINAL;
            end else begin
              idx_d     = idx_q + 1'b1;
              rd_addr_d = idx_q + 1'b1;
              state_d   = ST_DUMP_REQ;
            end
          end
        end
        default: begin
          state_d = ST_FINAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      tnum_q      <= '0;
      pass_sh_q   <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      testnum_q   <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      tnum_q      <= tnum_d;
      pass_sh_q   <= pass_sh_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      testnum_q   <= testnum_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  assign rd_addr      = rd_addr_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign fail_testnum = testnum_q;
  assign cycle_cnt    = cycle_q;
  assign instret_cnt  = instret_q;
  assign dump_valid   = (state_q == ST_DUMP_OUT);
  assign dump_idx     = idx_q;
  assign dump_data    = dump_data_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// tb/tb_test_status_monitor.sv - randomized self-checking bench for test_status_monitor
// Two instances share stimulus: a TIMEOUT=100 monitor and a CNT_W=4 monitor for saturation.
module tb_test_status_monitor;
  localparam int  TO_CYC = 100;
  localparam int  NR     = 32;
  localparam longint MAX32 = 64'd4294967295;

  logic        clk = 1'b0;
  logic        rst, clear, wb_en, retire, dump_ready;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [63:0] rf [NR];

  logic [4:0]  rd_addr, dump_idx;
  logic [63:0] rd_data, fail_testnum, dump_data;
  logic        done, pass, fail, timeout, dump_valid;
  logic [31:0] cycle_cnt, instret_cnt;

  logic [4:0]  rd_addr_s, dump_idx_s;
  logic [63:0] rd_data_s, fail_testnum_s, dump_data_s;
  logic        done_s, pass_s, fail_s, timeout_s, dump_valid_s;
  logic [3:0]  cycle_cnt_s, instret_cnt_s;

  int checks = 0;
  int errors = 0;

  bit          m_running, m_done, m_pass, m_fail, m_tout;
  longint      m_cyc, m_ins;
  logic [63:0] m_tnum, m_passv, m_testnum;

  always #5 clk = ~clk;

  assign rd_data   = rf[rd_addr];
  assign rd_data_s = rf[rd_addr_s];

  test_status_monitor #(.TIMEOUT(TO_CYC)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire(retire), .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_testnum(fail_testnum), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data)
  );

  test_status_monitor #(.CNT_W(4), .TIMEOUT(0)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire(retire), .rd_addr(rd_addr_s), .rd_data(rd_data_s), .done(done_s), .pass(pass_s),
    .fail(fail_s), .timeout(timeout_s), .fail_testnum(fail_testnum_s), .cycle_cnt(cycle_cnt_s),
    .instret_cnt(instret_cnt_s), .dump_valid(dump_valid_s), .dump_ready(dump_ready),
    .dump_idx(dump_idx_s), .dump_data(dump_data_s)
  );

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_running = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_tout = 1'b0;
    m_cyc = 0; m_ins = 0; m_tnum = '0; m_passv = '0; m_testnum = '0;
  endtask

  task automatic rand_rf();
    rf[0] = '0;
    for (int i = 1; i < NR; i++) rf[i] = {$urandom, $urandom};
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_reset();
  endtask

  // One core cycle of stimulus; the model follows the end-of-test rules at the outcome level.
  task automatic run_cycle(input logic en, input logic [4:0] a, input logic [63:0] d, input logic r);
    bit fin, to;
    wb_en = en; wb_addr = a; wb_data = d; retire = r;
    if (m_running) begin
      fin = en && (a == 5'd26) && (d == 64'd1);
      to  = !fin && (m_cyc == TO_CYC - 1);
      if (r) m_ins++;
      if (!to) m_cyc++;
      if (fin || to) begin m_running = 1'b0; m_done = 1'b1; m_testnum = m_tnum; end
      if (fin) begin if (m_passv == 64'd1) m_pass = 1'b1; else m_fail = 1'b1; end
      if (to) m_tout = 1'b1;
      if (en && a == 5'd3) m_tnum = d;
      if (en && a == 5'd27) m_passv = d;
    end
    if (en && a != 5'd0) rf[a] = d;
    step();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; retire = 1'b0;
  endtask

  task automatic advance_beats(input int n, output bit ok);
    int w;
    ok = 1'b1;
    for (int b = 0; b < n; b++) begin
      w = 0;
      while (!dump_valid && w < 8) begin step(); w++; end
      if (!dump_valid) begin ok = 1'b0; return; end
      dump_ready = 1'b1; step(); dump_ready = 1'b0;
    end
    w = 0;
    while (!dump_valid && w < 3) begin step(); w++; end
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; retire = 1'b0; dump_ready = 1'b0;
    repeat (2) step();
    checks++;
    if ({done, pass, fail, timeout, dump_valid, done_s, dump_valid_s} !== 7'b0 || cycle_cnt !== 0 ||
        instret_cnt !== 0 || fail_testnum !== 0 || rd_addr !== 0 || dump_idx !== 0 || dump_data !== 0)
      begin errors++; $display("FAIL reset_outputs: flags=%b cyc=%0d ins=%0d tn=%h rd=%0d", {done, pass, fail, timeout, dump_valid}, cycle_cnt, instret_cnt, fail_testnum, rd_addr); end
    rst = 1'b1;
    m_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 5'd0, 64'd0, 1'b1);
    checks++;
    if (cycle_cnt !== 32'(m_cyc) || instret_cnt !== 32'(m_ins))
      begin errors++; $display("FAIL reset_run: cyc=%0d ins=%0d want %0d/%0d", cycle_cnt, instret_cnt, m_cyc, m_ins); end
  endtask

  task automatic test_pass();
    logic [63:0] tn;
    tn = {$urandom, $urandom};
    do_clear();
    run_cycle(1'b1, 5'd3, tn, 1'b1);
    run_cycle(1'b1, 5'd27, 64'd1, 1'b1);
    repeat ($urandom_range(10, 3)) run_cycle(1'b0, 5'd0, 64'd0, 1'($urandom_range(1, 0)));
    run_cycle(1'b1, 5'd26, 64'd1, 1'b1);
    checks++;
    if ({done, pass, fail, timeout, dump_valid} !== {m_done, m_pass, m_fail, m_tout, 1'b0} || !m_pass)
      begin errors++; $display("FAIL pass_flags: got %b want %b", {done, pass, fail, timeout, dump_valid}, {m_done, m_pass, m_fail, m_tout, 1'b0}); end
    checks++;
    if (fail_testnum !== m_testnum)
      begin errors++; $display("FAIL pass_testnum: got %h want %h", fail_testnum, m_testnum); end
    repeat (3) run_cycle(1'b0, 5'd0, 64'd0, 1'b1);
    checks++;
    if (cycle_cnt !== 32'(m_cyc) || instret_cnt !== 32'(m_ins) || dump_valid !== 1'b0 || pass !== 1'b1)
      begin errors++; $display("FAIL pass_frozen: cyc=%0d ins=%0d want %0d/%0d dv=%b", cycle_cnt, instret_cnt, m_cyc, m_ins, dump_valid); end
  endtask

  task automatic test_fail_dump();
    int w;
    rand_rf();
    do_clear();
    run_cycle(1'b1, 5'd3, 64'd5, 1'b0);
    run_cycle(1'b1, 5'd27, 64'd0, 1'b1);
    run_cycle(1'b1, 5'd26, 64'd1, 1'b1);
    checks++;
    if ({done, pass, fail, timeout} !== {m_done, m_pass, m_fail, m_tout} || !m_fail || fail_testnum !== 64'd5)
      begin errors++; $display("FAIL fail_flags: got %b tn=%0d want %b tn=5", {done, pass, fail, timeout}, fail_testnum, {m_done, m_pass, m_fail, m_tout}); end
    checks++;
    if (dump_valid !== 1'b0 || rd_addr !== 5'd0)
      begin errors++; $display("FAIL dump_req0: dv=%b rd=%0d want 0/0", dump_valid, rd_addr); end
    for (int b = 0; b < NR; b++) begin
      w = 0;
      while (!dump_valid && w < 8) begin step(); w++; end
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'(b) || dump_data !== rf[b])
        begin errors++; $display("FAIL dump_beat: dv=%b idx=%0d data=%h want 1/%0d/%h", dump_valid, dump_idx, dump_data, b, rf[b]); end
      if (b == 7) begin
        repeat (3) begin
          step();
          checks++;
          if (dump_valid !== 1'b1 || dump_idx !== 5'd7 || dump_data !== rf[7])
            begin errors++; $display("FAIL dump_hold: dv=%b idx=%0d data=%h want 1/7/%h", dump_valid, dump_idx, dump_data, rf[7]); end
        end
      end else begin
        repeat ($urandom_range(1, 0)) step();
      end
      dump_ready = 1'b1; step(); dump_ready = 1'b0;
      checks++;
      if (dump_valid !== 1'b0 || (b < NR - 1 && rd_addr !== 5'(b + 1)))
        begin errors++; $display("FAIL dump_gap: dv=%b rd=%0d want 0/%0d", dump_valid, rd_addr, b + 1); end
    end
    repeat (2) step();
    checks++;
    if (dump_valid !== 1'b0 || rd_addr !== 5'd0 || {done, fail} !== 2'b11)
      begin errors++; $display("FAIL dump_final: dv=%b rd=%0d df=%b want 0/0/11", dump_valid, rd_addr, {done, fail}); end
  endtask

  task automatic test_ignored();
    logic [63:0] tn;
    tn = {32'd0, $urandom};
    do_clear();
    run_cycle(1'b1, 5'd3, tn, 1'b1);
    run_cycle(1'b1, 5'd26, 64'd2, 1'b0);
    checks++;
    if ({done, pass, fail, timeout} !== 4'b0000 || m_done)
      begin errors++; $display("FAIL ign_x26_2: got %b want 0000", {done, pass, fail, timeout}); end
    run_cycle(1'b1, 5'd0, 64'd1, 1'b0);
    run_cycle(1'b0, 5'd26, 64'd1, 1'b0);
    checks++;
    if ({done, pass, fail, timeout} !== 4'b0000 || rf[0] !== 64'd0)
      begin errors++; $display("FAIL ign_x0: got %b want 0000", {done, pass, fail, timeout}); end
    run_cycle(1'b1, 5'd27, 64'd1, 1'b0);
    run_cycle(1'b1, 5'd26, 64'd1, 1'b0);
    checks++;
    if ({done, pass, fail, timeout} !== {m_done, m_pass, m_fail, m_tout} || fail_testnum !== tn)
      begin errors++; $display("FAIL ign_pass: got %b tn=%h want %b tn=%h", {done, pass, fail, timeout}, fail_testnum, {m_done, m_pass, m_fail, m_tout}, tn); end
    run_cycle(1'b1, 5'd27, 64'd0, 1'b0);
    run_cycle(1'b1, 5'd3, tn + 64'd1, 1'b0);
    run_cycle(1'b1, 5'd26, 64'd1, 1'b1);
    checks++;
    if ({done, pass, fail, timeout, dump_valid} !== 5'b11000 || fail_testnum !== tn || cycle_cnt !== 32'(m_cyc) || instret_cnt !== 32'(m_ins))
      begin errors++; $display("FAIL ign_final: got %b tn=%h cyc=%0d want 11000 tn=%h cyc=%0d", {done, pass, fail, timeout, dump_valid}, fail_testnum, cycle_cnt, tn, m_cyc); end
  endtask

  task automatic test_counters();
    bit pat [50];
    bit t;
    int j;
    for (int i = 0; i < 50; i++) pat[i] = (i < 40);
    for (int i = 49; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = pat[i]; pat[i] = pat[j]; pat[j] = t;
    end
    do_clear();
    for (int i = 0; i < 50; i++) run_cycle(1'b0, 5'd0, 64'd0, pat[i]);
    checks++;
    if (instret_cnt !== 32'd40 || cycle_cnt !== 32'd50 || m_ins != 40)
      begin errors++; $display("FAIL cnt_40_50: ins=%0d cyc=%0d want 40/50", instret_cnt, cycle_cnt); end
  endtask

  task automatic test_saturate();
    do_clear();
    repeat (20) run_cycle(1'b0, 5'd0, 64'd0, 1'b1);
    checks++;
    if (cycle_cnt_s !== 4'(sat(m_cyc, 15)) || instret_cnt_s !== 4'(sat(m_ins, 15)))
      begin errors++; $display("FAIL sat_4bit: cyc=%0d ins=%0d want %0d/%0d", cycle_cnt_s, instret_cnt_s, sat(m_cyc, 15), sat(m_ins, 15)); end
    checks++;
    if (cycle_cnt !== 32'(sat(m_cyc, MAX32)) || instret_cnt !== 32'(sat(m_ins, MAX32)))
      begin errors++; $display("FAIL sat_32bit: cyc=%0d ins=%0d want %0d/%0d", cycle_cnt, instret_cnt, m_cyc, m_ins); end
  endtask

  task automatic test_timeout();
    bit ok;
    rand_rf();
    do_clear();
    run_cycle(1'b1, 5'd3, {32'd0, $urandom}, 1'b0);
    repeat (98) run_cycle(1'b0, 5'd0, 64'd0, 1'($urandom_range(1, 0)));
    checks++;
    if ({done, timeout} !== 2'b00 || cycle_cnt !== 32'd99)
      begin errors++; $display("FAIL to_before: dt=%b cyc=%0d want 00/99", {done, timeout}, cycle_cnt); end
    run_cycle(1'b0, 5'd0, 64'd0, 1'b1);
    checks++;
    if ({done, pass, fail, timeout} !== {m_done, m_pass, m_fail, m_tout} || !m_tout || cycle_cnt !== 32'd99 ||
        instret_cnt !== 32'(m_ins) || fail_testnum !== m_testnum)
      begin errors++; $display("FAIL to_fire: got %b cyc=%0d ins=%0d want %b cyc=99 ins=%0d", {done, pass, fail, timeout}, cycle_cnt, instret_cnt, {m_done, m_pass, m_fail, m_tout}, m_ins); end
    advance_beats(5, ok);
    checks++;
    if (!ok || dump_valid !== 1'b1 || dump_idx !== 5'd5 || dump_data !== rf[5])
      begin errors++; $display("FAIL to_dump: ok=%b dv=%b idx=%0d data=%h want 1/1/5/%h", ok, dump_valid, dump_idx, dump_data, rf[5]); end
    advance_beats(NR - 5, ok);
    checks++;
    if (!ok || dump_valid !== 1'b0 || cycle_cnt !== 32'd99 || {done, timeout} !== 2'b11)
      begin errors++; $display("FAIL to_final: ok=%b dv=%b cyc=%0d dt=%b want 1/0/99/11", ok, dump_valid, cycle_cnt, {done, timeout}); end
  endtask

  task automatic test_finish_99();
    bit pv;
    pv = 1'($urandom_range(1, 0));
    do_clear();
    run_cycle(1'b1, 5'd27, {63'd0, pv}, 1'b0);
    repeat (98) run_cycle(1'b0, 5'd0, 64'd0, 1'($urandom_range(1, 0)));
    run_cycle(1'b1, 5'd26, 64'd1, 1'b1);
    checks++;
    if ({done, pass, fail, timeout} !== {m_done, m_pass, m_fail, m_tout} || timeout !== 1'b0 || pass !== pv ||
        cycle_cnt !== 32'(m_cyc))
      begin errors++; $display("FAIL fin_99: got %b cyc=%0d want %b cyc=%0d", {done, pass, fail, timeout}, cycle_cnt, {m_done, m_pass, m_fail, m_tout}, m_cyc); end
  endtask

  task automatic test_rst_mid_dump();
    bit ok;
    rand_rf();
    do_clear();
    run_cycle(1'b1, 5'd3, {32'd0, $urandom}, 1'b0);
    run_cycle(1'b1, 5'd27, 64'd0, 1'b0);
    run_cycle(1'b1, 5'd26, 64'd1, 1'b0);
    advance_beats(10, ok);
    checks++;
    if (!ok || dump_valid !== 1'b1 || dump_idx !== 5'd10)
      begin errors++; $display("FAIL rst_beat10: ok=%b dv=%b idx=%0d want 1/1/10", ok, dump_valid, dump_idx); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({done, pass, fail, timeout, dump_valid} !== 5'b0 || cycle_cnt !== 0 || instret_cnt !== 0 ||
        fail_testnum !== 0 || rd_addr !== 0 || dump_idx !== 0 || dump_data !== 0)
      begin errors++; $display("FAIL rst_mid: flags=%b idx=%0d rd=%0d cyc=%0d", {done, pass, fail, timeout, dump_valid}, dump_idx, rd_addr, cycle_cnt); end
    step();
    rst = 1'b1;
    m_reset();
    run_cycle(1'b1, 5'd27, 64'd1, 1'b0);
    run_cycle(1'b1, 5'd26, 64'd1, 1'b1);
    checks++;
    if ({done, pass, fail, timeout, dump_valid} !== {m_done, m_pass, m_fail, m_tout, 1'b0} || cycle_cnt !== 32'(m_cyc))
      begin errors++; $display("FAIL rst_rerun: got %b cyc=%0d want %b cyc=%0d", {done, pass, fail, timeout, dump_valid}, cycle_cnt, {m_done, m_pass, m_fail, m_tout, 1'b0}, m_cyc); end
  endtask

  task automatic test_clear_mid_dump();
    bit ok;
    rand_rf();
    do_clear();
    run_cycle(1'b1, 5'd27, 64'd3, 1'b0);
    run_cycle(1'b1, 5'd26, 64'd1, 1'b0);
    advance_beats(3, ok);
    dump_ready = 1'b1;
    do_clear();
    dump_ready = 1'b0;
    checks++;
    if (!ok || {done, pass, fail, timeout, dump_valid} !== 5'b0 || cycle_cnt !== 0 || instret_cnt !== 0 || dump_idx !== 0)
      begin errors++; $display("FAIL clr_mid: ok=%b flags=%b cyc=%0d idx=%0d want 1/00000/0/0", ok, {done, pass, fail, timeout, dump_valid}, cycle_cnt, dump_idx); end
    run_cycle(1'b1, 5'd27, 64'd1, 1'b1);
    run_cycle(1'b0, 5'd0, 64'd0, 1'b1);
    run_cycle(1'b1, 5'd26, 64'd1, 1'b1);
    checks++;
    if ({done, pass, fail, timeout, dump_valid} !== {m_done, m_pass, m_fail, m_tout, 1'b0} ||
        cycle_cnt !== 32'(m_cyc) || instret_cnt !== 32'(m_ins))
      begin errors++; $display("FAIL clr_rerun: got %b cyc=%0d ins=%0d want %b %0d/%0d", {done, pass, fail, timeout, dump_valid}, cycle_cnt, instret_cnt, {m_done, m_pass, m_fail, m_tout, 1'b0}, m_cyc, m_ins); end
  endtask

  initial begin
    rand_rf();
    m_reset();
    test_reset();
    test_pass();
    test_fail_dump();
    test_ignored();
    test_counters();
    test_saturate();
    test_timeout();
    test_finish_99();
    test_rst_mid_dump();
    test_clear_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
